// File: rtl/lcd_id_reader.sv
`default_nettype none
// ============================================================================
// Module   : lcd_id_reader
// Brief    : Power-up RGB panel identification from the M2/M1/M0 mode straps.
//            Define LCD_ID_DEBOUNCE_EN for multi-sample debounce and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_id_reader #(
    parameter int SETTLE_CYC  = 100000,
    parameter int SAMPLE_GAP  = 1000,
    parameter int STABLE_CNT  = 16,
    parameter int MAX_SAMPLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] lcd_rgb_in,
    input  logic        rescan,
    output logic        rgb_oe,
    output logic [15:0] lcd_id,
    output logic        id_valid,
    output logic        id_err
);

    localparam int c_set_w = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int c_gap_w = $clog2(SAMPLE_GAP);
    localparam logic [c_set_w-1:0] c_settle_last = c_set_w'(SETTLE_CYC - 1);
    localparam logic [c_gap_w-1:0] c_gap_last    = c_gap_w'(SAMPLE_GAP - 1);

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [2:0]           r_sync1, r_sync2;
    logic [c_set_w-1:0]   r_settle, w_settle_nxt;
    logic [c_gap_w-1:0]   r_gap, w_gap_nxt;
    logic [2:0]           r_smp, w_smp_nxt;
    logic                 r_oe, w_oe_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_err, w_err_nxt;
    logic [15:0]          r_id, w_id_nxt;
    logic [15:0]          w_dec_id;
    logic                 w_dec_bad;
    logic                 w_unused;

`ifdef LCD_ID_DEBOUNCE_EN
    localparam int c_stb_w = $clog2(STABLE_CNT + 1);
    localparam int c_smp_w = $clog2(MAX_SAMPLES + 1);
    localparam logic [c_stb_w-1:0] c_stable_done  = c_stb_w'(STABLE_CNT);
    localparam logic [c_smp_w-1:0] c_samples_done = c_smp_w'(MAX_SAMPLES);

    logic [c_stb_w-1:0]   r_stable, w_stable_nxt;
    logic [c_smp_w-1:0]   r_samples, w_samples_nxt;
    localparam logic c_unused_cfg = 1'b0;
`else
    logic                 r_have, w_have_nxt;
    localparam logic c_unused_cfg = (STABLE_CNT + MAX_SAMPLES) > 0;
`endif

    // Only the MSB of each colour lane carries a strap.
    assign w_unused = ^{lcd_rgb_in[22:16], lcd_rgb_in[14:8], lcd_rgb_in[6:0], c_unused_cfg};

    assign rgb_oe   = r_oe;
    assign lcd_id   = r_id;
    assign id_valid = r_valid;
    assign id_err   = r_err;

    always_comb begin
        w_dec_id  = 16'd0;
        w_dec_bad = 1'b0;
        case (r_smp)
            3'b000:  w_dec_id = 16'd0;
            3'b001:  w_dec_id = 16'd1;
            3'b010:  w_dec_id = 16'd2;
            3'b100:  w_dec_id = 16'd5;
            default: w_dec_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_SETTLE;
            r_sync1   <= 3'b000;
            r_sync2   <= 3'b000;
            r_settle  <= '0;
            r_gap     <= '0;
            r_smp     <= 3'b000;
            r_oe      <= 1'b0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_id      <= 16'd0;
`ifdef LCD_ID_DEBOUNCE_EN
            r_stable  <= '0;
            r_samples <= '0;
`else
            r_have    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_sync1   <= {lcd_rgb_in[7], lcd_rgb_in[15], lcd_rgb_in[23]};
            r_sync2   <= r_sync1;
            r_settle  <= w_settle_nxt;
            r_gap     <= w_gap_nxt;
            r_smp     <= w_smp_nxt;
            r_oe      <= w_oe_nxt;
            r_valid   <= w_valid_nxt;
            r_err     <= w_err_nxt;
            r_id      <= w_id_nxt;
`ifdef LCD_ID_DEBOUNCE_EN
            r_stable  <= w_stable_nxt;
            r_samples <= w_samples_nxt;
`else
            r_have    <= w_have_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_settle_nxt  = r_settle;
        w_gap_nxt     = r_gap;
        w_smp_nxt     = r_smp;
        w_oe_nxt      = r_oe;
        w_valid_nxt   = r_valid;
        w_err_nxt     = r_err;
        w_id_nxt      = r_id;
`ifdef LCD_ID_DEBOUNCE_EN
        w_stable_nxt  = r_stable;
        w_samples_nxt = r_samples;
`else
        w_have_nxt    = r_have;
`endif
        case (r_state)
            ST_SETTLE: begin
                w_oe_nxt = 1'b0;
                if (r_settle == c_settle_last) begin
                    w_state_nxt   = ST_SAMPLE;
                    w_settle_nxt  = '0;
                    w_gap_nxt     = '0;
`ifdef LCD_ID_DEBOUNCE_EN
                    w_stable_nxt  = '0;
                    w_samples_nxt = '0;
`else
                    w_have_nxt    = 1'b0;
`endif
                end else begin
                    w_settle_nxt = r_settle + c_set_w'(1);
                end
            end
            ST_SAMPLE: begin
`ifdef LCD_ID_DEBOUNCE_EN
                // Acceptance is resolved one cycle after the deciding sample.
                if (r_stable == c_stable_done) begin
                    w_state_nxt = ST_DONE;
                    w_id_nxt    = w_dec_id;
                    w_err_nxt   = w_dec_bad;
                    w_valid_nxt = 1'b1;
                    w_oe_nxt    = 1'b1;
                end else if (r_samples == c_samples_done) begin
                    w_state_nxt = ST_DONE;
                    w_id_nxt    = 16'd0;
                    w_err_nxt   = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_oe_nxt    = 1'b1;
                end else if (r_gap == c_gap_last) begin
                    w_gap_nxt     = '0;
                    w_samples_nxt = r_samples + c_smp_w'(1);
                    if ((r_stable != '0) && (r_sync2 == r_smp)) begin
                        w_stable_nxt = r_stable + c_stb_w'(1);
                    end else begin
                        w_smp_nxt    = r_sync2;
                        w_stable_nxt = c_stb_w'(1);
                    end
                end else begin
                    w_gap_nxt = r_gap + c_gap_w'(1);
                end
`else
                if (r_have) begin
                    w_state_nxt = ST_DONE;
                    w_id_nxt    = w_dec_id;
                    w_err_nxt   = w_dec_bad;
                    w_valid_nxt = 1'b1;
                    w_oe_nxt    = 1'b1;
                end else if (r_gap == c_gap_last) begin
                    w_gap_nxt  = '0;
                    w_smp_nxt  = r_sync2;
                    w_have_nxt = 1'b1;
                end else begin
                    w_gap_nxt = r_gap + c_gap_w'(1);
                end
`endif
            end
            ST_DONE: begin
                // lcd_id is deliberately left holding the previous result.
                if (rescan) begin
                    w_state_nxt  = ST_SETTLE;
                    w_settle_nxt = '0;
                    w_valid_nxt  = 1'b0;
                    w_err_nxt    = 1'b0;
                    w_oe_nxt     = 1'b0;
                end
            end
            default: begin
                w_state_nxt  = ST_SETTLE;
                w_settle_nxt = '0;
                w_valid_nxt  = 1'b0;
                w_err_nxt    = 1'b0;
                w_oe_nxt     = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_id_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_id_reader
// Brief    : Directed self-checking bench for lcd_id_reader (20/5/4/8 config).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_id_reader;

`ifdef LCD_ID_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif
    localparam int T_DONE = DEB ? 41 : 26;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rescan = 1'b0;
    logic [23:0] lcd_rgb_in = 24'd0;
    logic        rgb_oe;
    logic [15:0] lcd_id;
    logic        id_valid;
    logic        id_err;

    int n_checks = 0;
    int n_fail   = 0;

    lcd_id_reader #(
        .SETTLE_CYC (20),
        .SAMPLE_GAP (5),
        .STABLE_CNT (4),
        .MAX_SAMPLES(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lcd_rgb_in(lcd_rgb_in),
        .rescan    (rescan),
        .rgb_oe    (rgb_oe),
        .lcd_id    (lcd_id),
        .id_valid  (id_valid),
        .id_err    (id_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // m = {M2,M1,M0}; non-strap bits carry noise that must be ignored.
    task automatic set_straps(input logic [2:0] m);
        lcd_rgb_in = {m[0], 7'h5A, m[1], 7'h3C, m[2], 7'h69};
    endtask

    task automatic run_to_done(output int n, output bit oe_early);
        n = 0;
        oe_early = 1'b0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (id_valid) break;
            if (rgb_oe) oe_early = 1'b1;
        end
    endtask

    task automatic start_from_reset(input logic [2:0] m);
        @(negedge clk);
        rst_n = 1'b0;
        set_straps(m);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_straps(3'b001);
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (rgb_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b required 0", rgb_oe); end
        n_checks++; if (lcd_id !== 16'd0) begin n_fail++; $display("FAIL reset_id: got %0d required 0", lcd_id); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", id_valid); end
        n_checks++; if (id_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", id_err); end
    endtask

    task automatic test_stable;
        int n;
        bit early;
        @(negedge clk);
        rst_n = 1'b1;
        run_to_done(n, early);
        n_checks++; if (n !== T_DONE) begin n_fail++; $display("FAIL stable_time: got %0d required %0d", n, T_DONE); end
        n_checks++; if (lcd_id !== 16'd1) begin n_fail++; $display("FAIL stable_id: got %0d required 1", lcd_id); end
        n_checks++; if (id_err !== 1'b0) begin n_fail++; $display("FAIL stable_err: got %b required 0", id_err); end
        n_checks++; if (rgb_oe !== 1'b1) begin n_fail++; $display("FAIL stable_oe: got %b required 1", rgb_oe); end
        n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL stable_oe_early: got %b required 0", early); end
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if ({rgb_oe, id_valid, lcd_id} !== {2'b11, 16'd1}) begin
            n_fail++; $display("FAIL stable_hold: got %b/%b/%0d required 1/1/1", rgb_oe, id_valid, lcd_id);
        end
    endtask

    task automatic test_glitch;
        int n;
        bit early;
        start_from_reset(3'b100);
        fork
            begin
                repeat (27) @(negedge clk);
                set_straps(3'b000);
                repeat (5) @(negedge clk);
                set_straps(3'b100);
            end
            run_to_done(n, early);
        join
        n_checks++; if (n !== (DEB ? 51 : 26)) begin n_fail++; $display("FAIL glitch_time: got %0d required %0d", n, DEB ? 51 : 26); end
        n_checks++; if (lcd_id !== 16'd5) begin n_fail++; $display("FAIL glitch_id: got %0d required 5", lcd_id); end
        n_checks++; if (id_err !== 1'b0) begin n_fail++; $display("FAIL glitch_err: got %b required 0", id_err); end
    endtask

    task automatic test_timeout;
        int n;
        bit early;
        logic [2:0] s;
        s = 3'b001;
        start_from_reset(s);
        fork
            begin
                repeat (27) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    s = s ^ 3'b001;
                    set_straps(s);
                    repeat (5) @(negedge clk);
                end
            end
            run_to_done(n, early);
        join
        n_checks++; if (n !== (DEB ? 61 : 26)) begin n_fail++; $display("FAIL timeout_time: got %0d required %0d", n, DEB ? 61 : 26); end
        n_checks++; if (lcd_id !== (DEB ? 16'd0 : 16'd1)) begin n_fail++; $display("FAIL timeout_id: got %0d required %0d", lcd_id, DEB ? 0 : 1); end
        n_checks++; if (id_err !== DEB) begin n_fail++; $display("FAIL timeout_err: got %b required %b", id_err, DEB); end
    endtask

    task automatic test_unknown;
        int n;
        bit early;
        start_from_reset(3'b011);
        run_to_done(n, early);
        n_checks++; if (n !== T_DONE) begin n_fail++; $display("FAIL unknown_time: got %0d required %0d", n, T_DONE); end
        n_checks++; if (lcd_id !== 16'd0) begin n_fail++; $display("FAIL unknown_id: got %0d required 0", lcd_id); end
        n_checks++; if (id_err !== 1'b1) begin n_fail++; $display("FAIL unknown_err: got %b required 1", id_err); end
        n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL unknown_valid: got %b required 1", id_valid); end
    endtask

    task automatic test_rescan;
        int n;
        bit early;
        start_from_reset(3'b010);
        run_to_done(n, early);
        n_checks++; if (lcd_id !== 16'd2) begin n_fail++; $display("FAIL rescan_first_id: got %0d required 2", lcd_id); end
        @(negedge clk);
        set_straps(3'b001);
        rescan = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (rgb_oe !== 1'b0) begin n_fail++; $display("FAIL rescan_oe_fall: got %b required 0", rgb_oe); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rescan_valid_fall: got %b required 0", id_valid); end
        n_checks++; if (lcd_id !== 16'd2) begin n_fail++; $display("FAIL rescan_id_hold: got %0d required 2", lcd_id); end
        @(negedge clk);
        rescan = 1'b0;
        // Stray rescan pulses in SETTLE and SAMPLE must not disturb timing.
        fork
            begin
                repeat (9) @(negedge clk);
                rescan = 1'b1;
                @(negedge clk);
                rescan = 1'b0;
                repeat (12) @(negedge clk);
                rescan = 1'b1;
                @(negedge clk);
                rescan = 1'b0;
            end
            run_to_done(n, early);
        join
        n_checks++; if (n !== T_DONE) begin n_fail++; $display("FAIL rescan_time: got %0d required %0d", n, T_DONE); end
        n_checks++; if ({id_valid, lcd_id} !== {1'b1, 16'd1}) begin n_fail++; $display("FAIL rescan_new_id: got %b/%0d required 1/1", id_valid, lcd_id); end
    endtask

    task automatic test_async_reset;
        int n;
        bit early;
        @(negedge clk);
        set_straps(3'b010);
        rescan = 1'b1;
        @(negedge clk);
        rescan = 1'b0;
        repeat (22) @(posedge clk);
        #1;
        n_checks++; if ({id_valid, lcd_id} !== {1'b0, 16'd1}) begin n_fail++; $display("FAIL arst_pre: got %b/%0d required 0/1", id_valid, lcd_id); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (lcd_id !== 16'd0) begin n_fail++; $display("FAIL arst_id: got %0d required 0", lcd_id); end
        n_checks++; if ({rgb_oe, id_valid, id_err} !== 3'b000) begin n_fail++; $display("FAIL arst_flags: got %b required 000", {rgb_oe, id_valid, id_err}); end
        @(negedge clk);
        rst_n = 1'b1;
        run_to_done(n, early);
        n_checks++; if (n !== T_DONE) begin n_fail++; $display("FAIL arst_restart_time: got %0d required %0d", n, T_DONE); end
        n_checks++; if (lcd_id !== 16'd2) begin n_fail++; $display("FAIL arst_restart_id: got %0d required 2", lcd_id); end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rgb_oe, id_valid, id_err, lcd_id} !== 19'd0) begin
            n_fail++; $display("FAIL arst_done: got %b/%b/%b/%0d required 0/0/0/0", rgb_oe, id_valid, id_err, lcd_id);
        end
    endtask

    initial begin
        test_reset();
        test_stable();
        test_glitch();
        test_timeout();
        test_unknown();
        test_rescan();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_id_reader.md
# lcd_id_reader

Power-up panel identification for the RGB LCD subsystem. After reset it releases the RGB data bus, waits for the panel strap pins to settle, samples the three mode straps (M2/M1/M0), debounces them, and produces the 16-bit panel code consumed by the pixel-clock divider and the LCD timing generator. It then hands the bus back to the display driver through `rgb_oe`.

## Interface
- `SETTLE_CYC`, default 100000: clk cycles of bus release before the first sample (1 ms at 100 MHz).
- `SAMPLE_GAP`, default 1000: clk cycles between consecutive strap samples; minimum 4.
- `STABLE_CNT`, default 16: number of consecutive identical samples needed to accept an ID; range 1 to 63.
- `MAX_SAMPLES`, default 64: sample budget before giving up with an error; must be at least `STABLE_CNT`.
- `clk` input, 1 bit: system clock, 100 MHz.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `lcd_rgb_in` input, 24 bits: RGB888 pad inputs. R occupies [23:16], G [15:8], B [7:0]. Asynchronous to `clk`.
- `rescan` input, 1 bit: single-cycle request to re-identify the panel. Honoured only in DONE.
- `rgb_oe` output, 1 bit: 0 while the bus is released for reading; 1 once the display driver may drive the bus.
- `lcd_id` output, 16 bits: panel code, zero-extended.
- `id_valid` output, 1 bit: high while `lcd_id` holds an accepted result.
- `id_err` output, 1 bit: high if the last scan timed out or decoded an unknown strap pattern.

## Operation
- Strap bits: M0 = `lcd_rgb_in[23]` (R7), M1 = `lcd_rgb_in[15]` (G7), M2 = `lcd_rgb_in[7]` (B7). They pass through a 2-flop synchronizer before use.
- Decode of {M2,M1,M0} to `lcd_id`:
  - 000 → 16'd0 (4.3" 480x272)
  - 001 → 16'd1 (7" 800x480)
  - 010 → 16'd2 (7" 1024x600)
  - 100 → 16'd5 (10.1" 1280x800)
  - any other pattern → 16'd0 with `id_err`=1
- States: SETTLE → SAMPLE → DONE. Reset enters SETTLE.
- SETTLE: `rgb_oe`=0. A counter runs for `SETTLE_CYC` cycles, then the block moves to SAMPLE with the gap counter and sample counter cleared.
- SAMPLE: the gap counter wraps every `SAMPLE_GAP` cycles, and the synchronized straps are sampled on the wrap cycle.
  - If the sample equals the stored sample, the stable count increments.
  - Otherwise the sample is stored and the stable count is set to 1.
  - When the stable count reaches `STABLE_CNT`, go to DONE with the decoded ID.
  - If `MAX_SAMPLES` samples are taken without reaching `STABLE_CNT`, go to DONE with `lcd_id`=0 and `id_err`=1.
- DONE: `id_valid`=1 and `rgb_oe`=1, and the outputs are held.
  - A `rescan` pulse returns the block to SETTLE: `id_valid`, `id_err` and `rgb_oe` go to 0.
  - `lcd_id` keeps its old value until the next DONE.
- `rescan` is ignored in SETTLE and SAMPLE.
- Counters are sized by `$clog2` of their parameter. No counter ever wraps past its terminal value.

## Timing
- Reset values: `rgb_oe`=0, `lcd_id`=16'd0, `id_valid`=0, `id_err`=0. The state is SETTLE and all counters are 0.
- First sample occurs `SETTLE_CYC`+`SAMPLE_GAP` cycles after the first clk edge with `rst_n` high.
- With stable straps, `id_valid`, `rgb_oe` and `lcd_id` update together exactly `SETTLE_CYC`+`STABLE_CNT`×`SAMPLE_GAP`+1 cycles after reset release. They are registered outputs.
- A strap change is seen 2 cycles later because of the synchronizer. A change within 2 cycles of a sample point belongs to the next sample.
- `rescan` in DONE: `rgb_oe`/`id_valid` go low on the next edge. Timing then restarts as if from reset release.
- Asserting `rst_n` low at any point returns all outputs to their reset values immediately (asynchronous).

## Configuration
- `LCD_ID_DEBOUNCE_EN` defined: multi-sample debounce and timeout as described above.
- `LCD_ID_DEBOUNCE_EN` undefined:
  - the first sample is accepted directly, so DONE is reached at `SETTLE_CYC`+`SAMPLE_GAP`+1;
  - `STABLE_CNT` and `MAX_SAMPLES` are unused, and no stable or sample counters are built;
  - `id_err` is set only for an unknown pattern.

## Test plan
Scenarios 1–4 use `SETTLE_CYC`=20, `SAMPLE_GAP`=5 and `STABLE_CNT`=4, with `LCD_ID_DEBOUNCE_EN` defined.
1. Straps fixed at 001 → `id_valid`, `rgb_oe`=1 at cycle 41, `lcd_id`=1, `id_err`=0. `rgb_oe`=0 throughout cycles 0–40.
2. Straps 100 with a single-sample glitch to 000 at the second sample → stable count restarts, DONE at cycle 51, `lcd_id`=5.
3. Straps toggling every sample with `MAX_SAMPLES`=8 → DONE after the 8th sample, `lcd_id`=0, `id_err`=1.
4. Straps 011 stable → `lcd_id`=0, `id_err`=1, `id_valid`=1.
5. In DONE with `lcd_id`=2, change straps to 001 and pulse `rescan`:
   - `rgb_oe`/`id_valid` fall the next cycle while `lcd_id` stays 2;
   - `lcd_id` becomes 1 with `id_valid`=1 after 41 cycles.
6. `rst_n` pulsed low mid-SAMPLE → all outputs return to reset values at once, and the full sequence restarts. Without `LCD_ID_DEBOUNCE_EN`, straps 010 → `lcd_id`=2 at cycle 26.
